cache_nway: RTL and testbench

- Parametrised N-way set-associative, write-back, write-allocate cache. Controller and datapath are combined in one block.
- Sits between the CPU memory port (32-bit word, byte-enable writes) and physical memory (256-bit cacheline).
- Successor to the fixed 2-way/8-set datapath. Adds a configurable way and set count, tree pseudo-LRU replacement, byte-merged write hits, dirty-victim writeback sequencing and saturating hit/miss counters.

---
 rtl/cache_nway_if.sv | 39 +++
 rtl/cache_nway.sv | 187 ++++++++++++++++++
 tb/tb_cache_nway.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_nway_if.sv
// Bus bundle between the CPU/physical-memory environment and cache_nway.
// The master side is the environment (CPU request plus pmem responder);
// the slave side is the cache itself.
interface cache_nway_if;
  // CPU memory port
  logic         mem_read;
  logic         mem_write;
  logic [3:0]   mem_byte_enable;
  logic [31:0]  mem_address;
  logic [31:0]  mem_wdata;
  logic [31:0]  mem_rdata;
  logic         mem_resp;
  // Physical memory port (one 256-bit line per transfer)
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  // Statistics
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;

  modport master (
    output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    output pmem_rdata, pmem_resp,
    input  mem_rdata, mem_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  hit_count, miss_count
  );

  modport slave (
    input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    input  pmem_rdata, pmem_resp,
    output mem_rdata, mem_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    output hit_count, miss_count
  );
endinterface

// File: rtl/cache_nway.sv
// N-way set-associative, write-back, write-allocate cache with tree
// pseudo-LRU replacement, byte-merged write hits, dirty-victim writeback
// and saturating hit/miss counters. Controller and datapath in one block.
module cache_nway #(
  parameter int NUM_WAYS = 2,
  parameter int NUM_SETS = 8
) (
  input logic         clk,
  input logic         rst,
  cache_nway_if.slave bus
);

  localparam int IDX_W    = $clog2(NUM_SETS);
  localparam int TAG_W    = 27 - IDX_W;
  localparam int LOG_WAYS = $clog2(NUM_WAYS);
  localparam int WAY_W    = (LOG_WAYS > 0) ? LOG_WAYS : 1;
  localparam int PLRU_W   = (NUM_WAYS > 1) ? NUM_WAYS - 1 : 1;
  localparam logic [WAY_W:0] NODE_ONE = (WAY_W+1)'(1);

  typedef enum logic [1:0] {CHECK, WRITEBACK, FILL} state_t;

  state_t               state_q;
  logic [WAY_W-1:0]     victimWay_q;
  logic                 refill_q;
  logic [31:0]          hitCount_q;
  logic [31:0]          missCount_q;
  logic [255:0]         data_q  [NUM_WAYS][NUM_SETS];
  logic [TAG_W-1:0]     tag_q   [NUM_WAYS][NUM_SETS];
  logic                 valid_q [NUM_WAYS][NUM_SETS];
  logic                 dirty_q [NUM_WAYS][NUM_SETS];
  logic [PLRU_W-1:0]    plru_q  [NUM_SETS];

  logic [IDX_W-1:0]     idx;
  logic [TAG_W-1:0]     reqTag;
  logic [2:0]           wordSel;
  logic                 request;
  logic                 isWrite;
  logic                 hit;
  logic [WAY_W-1:0]     hitWay;
  logic                 freeFound;
  logic [WAY_W-1:0]     freeWay;
  logic [WAY_W-1:0]     victimWay_d;
  logic [255:0]         hitLine;
  logic [255:0]         mergedLine;
  logic [1:0]           unusedAddrBits;

  // Walk the tree from the root: each node bit names the colder half.
  function automatic logic [WAY_W-1:0] plruVictim(input logic [PLRU_W-1:0] tree);
    logic [WAY_W:0]   node;
    logic [WAY_W-1:0] bitIdx;
    node = NODE_ONE;
    for (int l = 0; l < LOG_WAYS; l++) begin
      bitIdx = WAY_W'(node - NODE_ONE);
      node   = {node[WAY_W-1:0], tree[bitIdx]};
    end
    return (LOG_WAYS == 0) ? '0 : node[WAY_W-1:0];
  endfunction

  // Flip every node on the path to the accessed way so it points away from it.
  function automatic logic [PLRU_W-1:0] plruTouch(input logic [PLRU_W-1:0] tree,
                                                  input logic [WAY_W-1:0]  way);
    logic [PLRU_W-1:0] t;
    logic [WAY_W:0]    node;
    logic [WAY_W-1:0]  bitIdx;
    t    = tree;
    node = NODE_ONE;
    for (int l = LOG_WAYS - 1; l >= 0; l--) begin
      bitIdx    = WAY_W'(node - NODE_ONE);
      t[bitIdx] = ~way[l];
      node      = {node[WAY_W-1:0], way[l]};
    end
    return t;
  endfunction

  assign idx            = bus.mem_address[4+IDX_W:5];
  assign reqTag         = bus.mem_address[31:5+IDX_W];
  assign wordSel        = bus.mem_address[4:2];
  assign request        = bus.mem_read | bus.mem_write;
  assign isWrite        = bus.mem_write;
  assign unusedAddrBits = bus.mem_address[1:0];

  // Tag compare across all ways of the addressed set.
  always_comb begin
    hit    = 1'b0;
    hitWay = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[w][idx] && (tag_q[w][idx] == reqTag)) begin
        hit    = 1'b1;
        hitWay = WAY_W'(w);
      end
    end
  end

  // Victim choice: lowest-numbered invalid way, else the PLRU way.
  always_comb begin
    freeFound = 1'b0;
    freeWay   = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid_q[w][idx]) begin
        freeFound = 1'b1;
        freeWay   = WAY_W'(w);
      end
    end
    victimWay_d = freeFound ? freeWay : plruVictim(plru_q[idx]);
  end

  // Hit line read-out and byte merge of the CPU write into the selected word.
  always_comb begin
    hitLine    = data_q[hitWay][idx];
    mergedLine = hitLine;
    for (int b = 0; b < 4; b++) begin
      if (bus.mem_byte_enable[b]) begin
        mergedLine[32*int'(wordSel) + 8*b +: 8] = bus.mem_wdata[8*b +: 8];
      end
    end
  end

  assign bus.mem_rdata    = hitLine[32*int'(wordSel) +: 32];
  assign bus.mem_resp     = (state_q == CHECK) && request && hit;
  assign bus.pmem_read    = (state_q == FILL);
  assign bus.pmem_write   = (state_q == WRITEBACK);
  assign bus.pmem_address = (state_q == WRITEBACK)
                            ? {tag_q[victimWay_q][idx], idx, 5'b0}
                            : {bus.mem_address[31:5], 5'b0};
  assign bus.pmem_wdata   = data_q[victimWay_q][idx];
  assign bus.hit_count    = hitCount_q;
  assign bus.miss_count   = missCount_q;

  // Controller FSM plus valid/dirty/PLRU metadata and the statistics counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= CHECK;
      victimWay_q <= '0;
      refill_q    <= 1'b0;
      hitCount_q  <= '0;
      missCount_q <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        plru_q[s] <= '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
          valid_q[w][s] <= 1'b0;
          dirty_q[w][s] <= 1'b0;
        end
      end
    end else begin
      case (state_q)
        CHECK: begin
          refill_q <= 1'b0;
          if (request) begin
            if (hit) begin
              plru_q[idx] <= plruTouch(plru_q[idx], hitWay);
              if (isWrite) dirty_q[hitWay][idx] <= 1'b1;
              if (!refill_q && (hitCount_q != 32'hFFFF_FFFF)) hitCount_q <= hitCount_q + 32'd1;
            end else begin
              victimWay_q <= victimWay_d;
              if (missCount_q != 32'hFFFF_FFFF) missCount_q <= missCount_q + 32'd1;
              if (valid_q[victimWay_d][idx] && dirty_q[victimWay_d][idx]) state_q <= WRITEBACK;
              else state_q <= FILL;
            end
          end
        end
        WRITEBACK: begin
          if (bus.pmem_resp) state_q <= FILL;
        end
        FILL: begin
          if (bus.pmem_resp) begin
            valid_q[victimWay_q][idx] <= 1'b1;
            dirty_q[victimWay_q][idx] <= 1'b0;
            refill_q                  <= 1'b1;
            state_q                   <= CHECK;
          end
        end
        default: state_q <= CHECK;
      endcase
    end
  end

  // Line data and tag storage; contents are meaningless until valid is set.
  always_ff @(posedge clk) begin
    if ((state_q == FILL) && bus.pmem_resp) begin
      data_q[victimWay_q][idx] <= bus.pmem_rdata;
      tag_q[victimWay_q][idx]  <= reqTag;
    end else if ((state_q == CHECK) && request && hit && isWrite) begin
      data_q[hitWay][idx] <= mergedLine;
    end
  end

endmodule

// File: tb/tb_cache_nway.sv
// Directed bench for cache_nway: a default 2-way/8-set instance and a
// 4-way/16-set instance share one CPU driver and one pmem responder.
module tb_cache_nway;

  localparam int PMEM_LAT = 3;

  typedef struct {
    bit          isRead;
    logic [31:0] data;
    bit          hit;
    string       tag;
  } exp_t;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] word0;
  } pmemTxn_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         sel;
  logic         cpuRead, cpuWrite;
  logic [3:0]   cpuBe;
  logic [31:0]  cpuAddr, cpuWdata;
  logic [255:0] pmemRdata;
  logic         pmemResp;
  int           pmemCnt;

  int           vectors = 0;
  int           miscompares = 0;
  int           lastCycles;
  logic [31:0]  lastRdata;

  exp_t         expQ[$];
  pmemTxn_t     pmemLog[$];
  logic [255:0] memModel [logic [31:0]];
  logic [31:0]  shadow   [logic [31:0]];

  logic         obsResp, obsPRead, obsPWrite;
  logic [31:0]  obsRdata, obsPAddr, obsHits, obsMisses;
  logic [255:0] obsPWdata;

  cache_nway_if busA ();
  cache_nway_if busB ();

  assign busA.mem_read        = cpuRead & ~sel;
  assign busA.mem_write       = cpuWrite & ~sel;
  assign busA.mem_byte_enable = cpuBe;
  assign busA.mem_address     = cpuAddr;
  assign busA.mem_wdata       = cpuWdata;
  assign busA.pmem_rdata      = pmemRdata;
  assign busA.pmem_resp       = pmemResp & ~sel;
  assign busB.mem_read        = cpuRead & sel;
  assign busB.mem_write       = cpuWrite & sel;
  assign busB.mem_byte_enable = cpuBe;
  assign busB.mem_address     = cpuAddr;
  assign busB.mem_wdata       = cpuWdata;
  assign busB.pmem_rdata      = pmemRdata;
  assign busB.pmem_resp       = pmemResp & sel;

  assign obsResp   = sel ? busB.mem_resp     : busA.mem_resp;
  assign obsRdata  = sel ? busB.mem_rdata    : busA.mem_rdata;
  assign obsPRead  = sel ? busB.pmem_read    : busA.pmem_read;
  assign obsPWrite = sel ? busB.pmem_write   : busA.pmem_write;
  assign obsPAddr  = sel ? busB.pmem_address : busA.pmem_address;
  assign obsPWdata = sel ? busB.pmem_wdata   : busA.pmem_wdata;
  assign obsHits   = sel ? busB.hit_count    : busA.hit_count;
  assign obsMisses = sel ? busB.miss_count   : busA.miss_count;

  cache_nway #(.NUM_WAYS(2), .NUM_SETS(8)) dutA (.clk(clk), .rst(rst), .bus(busA.slave));
  cache_nway #(.NUM_WAYS(4), .NUM_SETS(16)) dutB (.clk(clk), .rst(rst), .bus(busB.slave));

  always #5 clk = ~clk;

  // Backing memory: untouched lines hold an address-derived pattern.
  function automatic logic [255:0] memLine(input logic [31:0] a);
    logic [255:0] l;
    if (memModel.exists(a)) return memModel[a];
    for (int k = 0; k < 8; k++) l[32*k +: 32] = a + 32'h0A0B_0000 + 32'(k);
    return l;
  endfunction

  // What the CPU should read: its own latest write, else memory contents.
  function automatic logic [31:0] golden(input logic [31:0] a);
    logic [255:0] l;
    logic [31:0]  wa;
    wa = {a[31:2], 2'b00};
    if (shadow.exists(wa)) return shadow[wa];
    l = memLine({a[31:5], 5'b0});
    return l[32*int'(a[4:2]) +: 32];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One CPU request: push the expectation, hold until mem_resp, pop and compare.
  task automatic applyStimulus(input bit wr, input logic [31:0] addr, input logic [3:0] be,
                               input logic [31:0] wd, input bit expHit, input string tag);
    exp_t        e;
    logic [31:0] w;
    int          cycles;
    bit          done;
    e.isRead = !wr;
    e.hit    = expHit;
    e.tag    = tag;
    e.data   = wr ? 32'h0 : golden(addr);
    if (wr) begin
      w = golden(addr);
      for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
      shadow[{addr[31:2], 2'b00}] = w;
    end
    expQ.push_back(e);
    pmemLog.delete();
    cpuRead = !wr; cpuWrite = wr; cpuAddr = addr; cpuBe = be; cpuWdata = wd;
    cycles = 0;
    done   = 1'b0;
    while (!done && cycles < 100) begin
      #1;
      if (obsResp) done = 1'b1;
      else begin
        @(negedge clk);
        cycles++;
      end
    end
    lastCycles = cycles;
    lastRdata  = obsRdata;
    e = expQ.pop_front();
    if (!done) checkOutput({e.tag, " mem_resp timeout"}, 32'd0, 32'd1);
    else begin
      if (e.isRead) checkOutput({e.tag, " rdata"}, obsRdata, e.data);
      checkOutput({e.tag, " hit"}, 32'(cycles == 0 && pmemLog.size() == 0), 32'(e.hit));
    end
    @(negedge clk);
    cpuRead = 1'b0; cpuWrite = 1'b0;
  endtask

  // pmem responder: answers each strobe after PMEM_LAT cycles and logs it.
  initial begin
    pmemTxn_t txn;
    pmemResp  = 1'b0;
    pmemRdata = '0;
    pmemCnt   = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pmemResp = 1'b0;
        pmemCnt  = 0;
      end else if (pmemResp) begin
        pmemResp = 1'b0;
        pmemCnt  = 0;
      end else if (obsPRead || obsPWrite) begin
        checkOutput("pmem strobes exclusive", 32'(obsPRead & obsPWrite), 32'd0);
        pmemCnt++;
        if (pmemCnt == PMEM_LAT) begin
          txn.wr    = obsPWrite;
          txn.addr  = obsPAddr;
          txn.word0 = obsPWdata[31:0];
          pmemLog.push_back(txn);
          if (obsPWrite) memModel[obsPAddr] = obsPWdata;
          else pmemRdata = memLine(obsPAddr);
          pmemResp = 1'b1;
        end
      end else pmemCnt = 0;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence of test steps.
  initial begin
    logic [255:0] l;
    int           waitCnt;
    sel = 1'b0; rst = 1'b1;
    cpuRead = 1'b0; cpuWrite = 1'b0; cpuBe = '0; cpuAddr = '0; cpuWdata = '0;
    l = memLine(32'h100);
    l[63:32] = 32'h1122_3344;
    memModel[32'h100] = l;

    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset hit_count", obsHits, 32'd0);
    checkOutput("reset miss_count", obsMisses, 32'd0);
    checkOutput("reset pmem_read", 32'(obsPRead), 32'd0);
    checkOutput("reset pmem_write", 32'(obsPWrite), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] cold read");
    applyStimulus(1'b0, 32'h104, 4'h0, 32'h0, 1'b0, "cold read");
    checkOutput("cold read word", lastRdata, 32'h1122_3344);
    checkOutput("cold read latency", 32'(lastCycles), 32'(PMEM_LAT + 1));
    checkOutput("cold read pmem txns", 32'(pmemLog.size()), 32'd1);
    if (pmemLog.size() == 1) begin
      checkOutput("cold read pmem kind", 32'(pmemLog[0].wr), 32'd0);
      checkOutput("cold read pmem addr", pmemLog[0].addr, 32'h100);
    end
    checkOutput("cold read hits", obsHits, 32'd0);
    checkOutput("cold read misses", obsMisses, 32'd1);

    $display("[TB] write hit merge");
    applyStimulus(1'b1, 32'h104, 4'b0011, 32'hAAAA_BBBB, 1'b1, "write hit");
    applyStimulus(1'b0, 32'h104, 4'h0, 32'h0, 1'b1, "merged read");
    checkOutput("merged word", lastRdata, 32'h1122_BBBB);
    checkOutput("merge hits", obsHits, 32'd2);

    $display("[TB] PLRU dirty eviction");
    applyStimulus(1'b0, 32'h100, 4'h0, 32'h0, 1'b1, "read 0x100");
    applyStimulus(1'b1, 32'h200, 4'hF, 32'hCAFE_F00D, 1'b0, "write 0x200");
    applyStimulus(1'b0, 32'h100, 4'h0, 32'h0, 1'b1, "touch 0x100");
    applyStimulus(1'b0, 32'h300, 4'h0, 32'h0, 1'b0, "read 0x300 dirty victim");
    checkOutput("dirty evict txns", 32'(pmemLog.size()), 32'd2);
    if (pmemLog.size() == 2) begin
      checkOutput("writeback kind", 32'(pmemLog[0].wr), 32'd1);
      checkOutput("writeback addr", pmemLog[0].addr, 32'h200);
      checkOutput("writeback data", pmemLog[0].word0, 32'hCAFE_F00D);
      checkOutput("refill kind", 32'(pmemLog[1].wr), 32'd0);
      checkOutput("refill addr", pmemLog[1].addr, 32'h300);
    end
    applyStimulus(1'b0, 32'h100, 4'h0, 32'h0, 1'b1, "re-read 0x100");

    // The dirty 0x104 line is dropped by this reset; that word is not read again.
    $display("[TB] reset mid-fill");
    cpuRead = 1'b1; cpuAddr = 32'h400; cpuBe = 4'h0;
    waitCnt = 0;
    #1;
    while (!obsPRead && waitCnt < 20) begin
      @(negedge clk);
      #1;
      waitCnt++;
    end
    checkOutput("fill before reset", 32'(obsPRead), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("abort pmem_read", 32'(obsPRead), 32'd0);
    checkOutput("abort mem_resp", 32'(obsResp), 32'd0);
    checkOutput("abort hits", obsHits, 32'd0);
    checkOutput("abort misses", obsMisses, 32'd0);
    cpuRead = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(1'b0, 32'h400, 4'h0, 32'h0, 1'b0, "re-read after reset");
    checkOutput("post-reset misses", obsMisses, 32'd1);

    $display("[TB] clean eviction");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(1'b0, 32'h100, 4'h0, 32'h0, 1'b0, "clean read 0x100");
    applyStimulus(1'b0, 32'h200, 4'h0, 32'h0, 1'b0, "clean read 0x200");
    applyStimulus(1'b0, 32'h100, 4'h0, 32'h0, 1'b1, "clean touch 0x100");
    applyStimulus(1'b0, 32'h300, 4'h0, 32'h0, 1'b0, "clean read 0x300");
    checkOutput("clean evict txns", 32'(pmemLog.size()), 32'd1);
    if (pmemLog.size() == 1) begin
      checkOutput("clean evict kind", 32'(pmemLog[0].wr), 32'd0);
      checkOutput("clean evict addr", pmemLog[0].addr, 32'h300);
    end
    applyStimulus(1'b0, 32'h100, 4'h0, 32'h0, 1'b1, "clean re-read 0x100");
    checkOutput("clean hits", obsHits, 32'd2);
    checkOutput("clean misses", obsMisses, 32'd3);

    // 4-way/16-set: tag t lives at 0x1000_0000 + t*0x200, all in set 0.
    // Fills land in ways 0..3; touching tag 1 leaves the tree pointing at way 2 (tag 3).
    $display("[TB] 4-way tree PLRU");
    sel = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int t = 1; t <= 4; t++)
      applyStimulus(1'b0, 32'h1000_0000 + 32'(t * 32'h200), 4'h0, 32'h0, 1'b0, $sformatf("4way fill tag %0d", t));
    applyStimulus(1'b0, 32'h1000_0200, 4'h0, 32'h0, 1'b1, "4way touch tag 1");
    applyStimulus(1'b0, 32'h1000_0A00, 4'h0, 32'h0, 1'b0, "4way read tag 5");
    checkOutput("4way tag 5 txns", 32'(pmemLog.size()), 32'd1);
    applyStimulus(1'b0, 32'h1000_0200, 4'h0, 32'h0, 1'b1, "4way keep tag 1");
    applyStimulus(1'b0, 32'h1000_0400, 4'h0, 32'h0, 1'b1, "4way keep tag 2");
    applyStimulus(1'b0, 32'h1000_0800, 4'h0, 32'h0, 1'b1, "4way keep tag 4");
    applyStimulus(1'b0, 32'h1000_0600, 4'h0, 32'h0, 1'b0, "4way evicted tag 3");
    checkOutput("4way hits", obsHits, 32'd4);
    checkOutput("4way misses", obsMisses, 32'd6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
